// File: rtl/cluster_acc_reduce.sv
// Folds P partitions of per-cluster {R,G,B} accumulators and pixel counts into one set of totals; done strobes P+1 cycles after start.
// No backpressure: start is ignored while busy. Define CLUSTER_ACC_REDUCE_EMPTY_FLAG_EN to build the per-cluster empty_mask.
module cluster_acc_reduce #(
  parameter int K  = 16,
  parameter int P  = 2,
  parameter int AW = 24,
  parameter int CW = 12
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [P*K*3*AW-1:0]                  acc_in,
  input  logic [P*K*CW-1:0]                    cnt_in,
  output logic                                 busy,
  output logic                                 done,
  output logic [K*3*(AW+$clog2(P))-1:0]        sum_acc,
  output logic [K*(CW+$clog2(P))-1:0]          sum_cnt,
  output logic [K-1:0]                         empty_mask
);

  localparam int LP  = $clog2(P);
  localparam int SW  = AW + LP;
  localparam int SCW = CW + LP;
  localparam int IW  = (LP < 1) ? 1 : LP;
  localparam int PAW = K * 3 * AW;
  localparam int PCW = K * CW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_clear;
  logic                w_add;
  logic                w_last;
  logic [IW-1:0]       r_idx;
  logic                r_busy;
  logic                r_done;

  logic [K*3*SW-1:0]   r_wacc;
  logic [K*3*SW-1:0]   w_wacc_nxt;
  logic [K*SCW-1:0]    r_wcnt;
  logic [K*SCW-1:0]    w_wcnt_nxt;
  logic [K*3*SW-1:0]   r_sum_acc;
  logic [K*SCW-1:0]    r_sum_cnt;

  logic [PAW-1:0]      w_part_acc [P];
  logic [PCW-1:0]      w_part_cnt [P];
  logic [PAW-1:0]      w_sel_acc;
  logic [PCW-1:0]      w_sel_cnt;

  for (genvar p = 0; p < P; p++) begin : g_part
    assign w_part_acc[p] = acc_in[p*PAW +: PAW];
    assign w_part_cnt[p] = cnt_in[p*PCW +: PCW];
  end

  assign w_sel_acc = w_part_acc[r_idx];
  assign w_sel_cnt = w_part_cnt[r_idx];

  // Field g = k*3 + colour lines up between input and sum layouts, so one flat loop covers all colours.
  for (genvar g = 0; g < K*3; g++) begin : g_acc_add
    assign w_wacc_nxt[g*SW +: SW] = r_wacc[g*SW +: SW] + SW'(w_sel_acc[g*AW +: AW]);
  end

  for (genvar k = 0; k < K; k++) begin : g_cnt_add
    assign w_wcnt_nxt[k*SCW +: SCW] = r_wcnt[k*SCW +: SCW] + SCW'(w_sel_cnt[k*CW +: CW]);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_add       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ACCUM;
          w_clear     = 1'b1;
        end
      end
      S_ACCUM: begin
        w_add = 1'b1;
        if (r_idx == IW'(P - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_last;
      if (w_clear || w_last) begin
        r_idx <= '0;
      end else if (w_add) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // The final add and the output copy share one edge, so results are valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wacc    <= '0;
      r_wcnt    <= '0;
      r_sum_acc <= '0;
      r_sum_cnt <= '0;
    end else begin
      if (w_clear) begin
        r_wacc <= '0;
        r_wcnt <= '0;
      end else if (w_add) begin
        r_wacc <= w_wacc_nxt;
        r_wcnt <= w_wcnt_nxt;
      end
      if (w_last) begin
        r_sum_acc <= w_wacc_nxt;
        r_sum_cnt <= w_wcnt_nxt;
      end
    end
  end

`ifdef CLUSTER_ACC_REDUCE_EMPTY_FLAG_EN
  logic [K-1:0] w_empty_nxt;
  logic [K-1:0] r_empty;

  for (genvar k = 0; k < K; k++) begin : g_empty
    assign w_empty_nxt[k] = (w_wcnt_nxt[k*SCW +: SCW] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_empty <= '0;
    end else if (w_last) begin
      r_empty <= w_empty_nxt;
    end
  end

  assign empty_mask = r_empty;
`else
  assign empty_mask = '0;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum_acc = r_sum_acc;
  assign sum_cnt = r_sum_cnt;

endmodule

// File: tb/tb_cluster_acc_reduce.sv
// Directed bench for cluster_acc_reduce: three instances (P=2/K=16, P=4/K=16, P=1/K=4) with hand-computed results.
module tb_cluster_acc_reduce;

`ifdef CLUSTER_ACC_REDUCE_EMPTY_FLAG_EN
  localparam bit EF = 1'b1;
`else
  localparam bit EF = 1'b0;
`endif
  localparam int CR = 2, CG = 1, CB = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic                   st2 = 1'b0;
  logic [2*16*3*24-1:0]   acc2 = '0;
  logic [2*16*12-1:0]     cnt2 = '0;
  logic                   busy2, done2;
  logic [16*3*25-1:0]     sacc2;
  logic [16*13-1:0]       scnt2;
  logic [15:0]            em2;

  logic                   st4 = 1'b0;
  logic [4*16*3*24-1:0]   acc4 = '0;
  logic [4*16*12-1:0]     cnt4 = '0;
  logic                   busy4, done4;
  logic [16*3*26-1:0]     sacc4;
  logic [16*14-1:0]       scnt4;
  logic [15:0]            em4;

  logic                   st1 = 1'b0;
  logic [4*3*24-1:0]      acc1 = '0;
  logic [4*12-1:0]        cnt1 = '0;
  logic                   busy1, done1;
  logic [4*3*24-1:0]      sacc1;
  logic [4*12-1:0]        scnt1;
  logic [3:0]             em1;

  cluster_acc_reduce #(.K(16), .P(2), .AW(24), .CW(12)) u_p2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .acc_in(acc2), .cnt_in(cnt2),
    .busy(busy2), .done(done2), .sum_acc(sacc2), .sum_cnt(scnt2), .empty_mask(em2));

  cluster_acc_reduce #(.K(16), .P(4), .AW(24), .CW(12)) u_p4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .acc_in(acc4), .cnt_in(cnt4),
    .busy(busy4), .done(done4), .sum_acc(sacc4), .sum_cnt(scnt4), .empty_mask(em4));

  cluster_acc_reduce #(.K(4), .P(1), .AW(24), .CW(12)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .acc_in(acc1), .cnt_in(cnt1),
    .busy(busy1), .done(done1), .sum_acc(sacc1), .sum_cnt(scnt1), .empty_mask(em1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set2(input int p, input int k, input logic [23:0] r, input logic [23:0] g,
                      input logic [23:0] b, input logic [11:0] c);
    acc2[((p*16+k)*3+CR)*24 +: 24] = r;
    acc2[((p*16+k)*3+CG)*24 +: 24] = g;
    acc2[((p*16+k)*3+CB)*24 +: 24] = b;
    cnt2[(p*16+k)*12 +: 12] = c;
  endtask

  task automatic set4(input int p, input int k, input logic [23:0] r, input logic [23:0] g,
                      input logic [23:0] b, input logic [11:0] c);
    acc4[((p*16+k)*3+CR)*24 +: 24] = r;
    acc4[((p*16+k)*3+CG)*24 +: 24] = g;
    acc4[((p*16+k)*3+CB)*24 +: 24] = b;
    cnt4[(p*16+k)*12 +: 12] = c;
  endtask

  function automatic logic [63:0] f2(input int k, input int c);
    return 64'(sacc2[(k*3+c)*25 +: 25]);
  endfunction
  function automatic logic [63:0] c2(input int k);
    return 64'(scnt2[k*13 +: 13]);
  endfunction
  function automatic logic [63:0] f4(input int k, input int c);
    return 64'(sacc4[(k*3+c)*26 +: 26]);
  endfunction
  function automatic logic [63:0] c4(input int k);
    return 64'(scnt4[k*14 +: 14]);
  endfunction
  function automatic logic [63:0] f1(input int k, input int c);
    return 64'(sacc1[(k*3+c)*24 +: 24]);
  endfunction
  function automatic logic [63:0] c1(input int k);
    return 64'(scnt1[k*12 +: 12]);
  endfunction

  function automatic logic dn(input int which);
    if (which == 1) return done1;
    if (which == 2) return done2;
    return done4;
  endfunction

  // Pulses start for one cycle and counts edges until done; capped so a dead DUT still reaches the summary.
  task automatic run(input int which, output int lat);
    if (which == 1) st1 = 1'b1;
    else if (which == 2) st2 = 1'b1;
    else st4 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        st1 = 1'b0; st2 = 1'b0; st4 = 1'b0;
      end
    end while (!dn(which) && lat < 40);
  endtask

  initial begin
    int lat;
    int bad;
    logic [63:0] oth;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy2", 64'(busy2), 0);
    chk("rst_done4", 64'(done4), 0);
    chk("rst_sacc2", 64'(|sacc2), 0);
    chk("rst_scnt4", 64'(|scnt4), 0);
    chk("rst_em2", 64'(em2), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic P=2 reduction on cluster 3 only.
    set2(0, 3, 24'd100, 24'd200, 24'd300, 12'd5);
    set2(1, 3, 24'd1, 24'd2, 24'd3, 12'd7);
    run(2, lat);
    chk("p2_latency", 64'(lat), 3);
    chk("p2_busy_at_done", 64'(busy2), 1);
    chk("p2_r3", f2(3, CR), 101);
    chk("p2_g3", f2(3, CG), 202);
    chk("p2_b3", f2(3, CB), 303);
    chk("p2_cnt3", c2(3), 12);
    oth = 0;
    for (int k = 0; k < 16; k++) begin
      if (k != 3) oth = oth | f2(k, CR) | f2(k, CG) | f2(k, CB) | c2(k);
    end
    chk("p2_others_zero", oth, 0);
    chk("p2_empty", 64'(em2), EF ? 64'hfff7 : 64'h0);
    @(posedge clk); #1;
    chk("p2_done_one_cycle", 64'(done2), 0);
    chk("p2_busy_after", 64'(busy2), 0);

    // Back-to-back: start held high through ACCUM/FINISH of run X, accepted in the cycle after done.
    acc2 = '0; cnt2 = '0;
    for (int k = 0; k < 16; k++) begin
      set2(0, k, 24'(k), 24'd0, 24'd0, (k == 2 || k == 7) ? 12'd0 : 12'd1);
      set2(1, k, 24'd0, 24'd0, 24'd3, (k == 2 || k == 7) ? 12'd0 : 12'd2);
    end
    st2 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done2 && lat < 40);
    chk("b2b_first_latency", 64'(lat), 3);
    chk("b2b_x_r5", f2(5, CR), 5);
    chk("b2b_x_b5", f2(5, CB), 3);
    chk("b2b_x_cnt5", c2(5), 3);
    chk("b2b_x_cnt2", c2(2), 0);
    chk("b2b_x_empty", 64'(em2), EF ? 64'h0084 : 64'h0);
    acc2 = '0; cnt2 = '0;
    for (int k = 0; k < 16; k++) set2(0, k, 24'd0, (k == 9) ? 24'd1000 : 24'd0, 24'd0, 12'd1);
    set2(1, 9, 24'd0, 24'd24, 24'd0, 12'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) st2 = 1'b0;
      if (lat == 3) chk("b2b_hold_r5", f2(5, CR), 5);
    end while (!done2 && lat < 40);
    st2 = 1'b0;
    chk("b2b_done_spacing", 64'(lat), 4);
    chk("b2b_y_g9", f2(9, CG), 1024);
    chk("b2b_y_r5", f2(5, CR), 0);
    chk("b2b_y_cnt9", c2(9), 1);
    chk("b2b_y_cnt2", c2(2), 1);
    chk("b2b_y_empty", 64'(em2), 0);

    // P=1: single ACCUM cycle, outputs are the inputs zero-extended.
    acc1[(3*3+CR)*24 +: 24] = 24'hffffff;
    acc1[(3*3+CG)*24 +: 24] = 24'h123456;
    acc1[(3*3+CB)*24 +: 24] = 24'h000001;
    cnt1[3*12 +: 12] = 12'habc;
    acc1[(0*3+CR)*24 +: 24] = 24'd7;
    run(1, lat);
    chk("p1_latency", 64'(lat), 2);
    chk("p1_r3", f1(3, CR), 64'hffffff);
    chk("p1_g3", f1(3, CG), 64'h123456);
    chk("p1_b3", f1(3, CB), 1);
    chk("p1_cnt3", c1(3), 64'habc);
    chk("p1_r0", f1(0, CR), 7);
    chk("p1_empty", 64'(em1), EF ? 64'h7 : 64'h0);

    // P=4 all-ones: largest possible sums without wrap.
    acc4 = '1; cnt4 = '1;
    run(4, lat);
    chk("max_latency", 64'(lat), 5);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 3; c++) if (f4(k, c) != 64'd67108860) bad++;
      if (c4(k) != 64'd16380) bad++;
    end
    chk("max_fields_bad", 64'(bad), 0);
    chk("max_r0", f4(0, CR), 67108860);
    chk("max_cnt15", c4(15), 16380);

    // Reset during ACCUM: everything clears immediately.
    acc4 = '0; cnt4 = '0;
    st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy4), 0);
    chk("mid_rst_done", 64'(done4), 0);
    chk("mid_rst_sacc", 64'(|sacc4), 0);
    chk("mid_rst_scnt", 64'(|scnt4), 0);
    chk("mid_rst_sacc_p2", 64'(|sacc2), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 16; k++) set4(p, k, 24'(p + 1), 24'(10 * k), 24'(k + p), 12'(k));
    end
    run(4, lat);
    chk("rec_latency", 64'(lat), 5);
    chk("rec_r5", f4(5, CR), 10);
    chk("rec_g5", f4(5, CG), 200);
    chk("rec_b5", f4(5, CB), 26);
    chk("rec_cnt5", c4(5), 20);
    chk("rec_b0", f4(0, CB), 6);
    chk("rec_g15", f4(15, CG), 600);
    chk("rec_cnt15", c4(15), 60);
    chk("rec_empty", 64'(em4), EF ? 64'h0001 : 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cluster_acc_reduce.md
# cluster_acc_reduce

Sequential, parametrised reducer that merges per-cluster colour accumulators and pixel counters produced by P parallel assignment engines into one set of cluster totals. It sits between the assignment engines and the centroid-update divider of the K-means pipeline. It handles any cluster count, partition count and field width. Results are registered, stable and signalled by a one-cycle `done` strobe.

## Interface

- `K`, 16: number of clusters.
- `P`, 2: number of partitions (engines) to reduce; ≥1.
- `AW`, 24: width of one colour accumulator (R, G or B) per engine.
- `CW`, 12: width of one pixel counter per engine.
- Derived, not overridable: `LP = $clog2(P)`, `SW = AW+LP`, `SCW = CW+LP`.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a reduction; sampled only in IDLE.
- `acc_in` in P*K*3*AW: partition p, cluster k at base `(p*K+k)*3*AW`; `{R,G,B}`, R in MSBs.
- `cnt_in` in P*K*CW: partition p, cluster k at `(p*K+k)*CW`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle strobe; outputs valid from that cycle.
- `sum_acc` out K*3*SW: cluster k at `k*3*SW`, `{R,G,B}`.
- `sum_cnt` out K*SCW: cluster k at `k*SCW`.
- `empty_mask` out K: bit k = cluster k total count is zero (see Configuration).

## Operation

- FSM states:
  - IDLE→ACCUM on `start`.
  - ACCUM→FINISH after partition P-1 is added.
  - FINISH→IDLE unconditionally.
- IDLE + `start`: clear working sums, set partition index `idx`=0.
- ACCUM: each cycle, add partition `idx` for all K clusters in parallel (3K colour adds, K count adds) into the working registers, then `idx++`.
  - On the `idx==P-1` add, go to FINISH.
- FINISH: copy working sums into `sum_acc`/`sum_cnt`/`empty_mask`; assert `done`.
- Arithmetic: unsigned, zero-extended to SW/SCW. It cannot overflow by construction, so there is no saturation and no wrap.
- `acc_in`/`cnt_in` must be held stable from the `start` cycle until `done`. The block does not snapshot them.
- `start` is ignored in ACCUM and FINISH; no queueing.
- A new `start` may be given the cycle after `done`.
- Outputs hold their last result until the next FINISH. Working registers are internal only.
- P=1: ACCUM lasts exactly one cycle. `idx` width is `max(1,LP)`.
- `rst_n` low at any time, including mid-ACCUM, aborts the operation, returns to IDLE, and clears all outputs.

## Timing

- Reset values: `busy`=0, `done`=0, `sum_acc`=0, `sum_cnt`=0, `empty_mask`=0, state=IDLE, `idx`=0.
- With `start` sampled at edge T0:
  - `busy`=1 from T0 through edge T0+P+1.
  - Partition i is added at edge T0+1+i.
  - FINISH is active between edges T0+P and T0+P+1; outputs update and `done`=1 for exactly that cycle.
- Latency from `start` to `done` is P+1 cycles. Throughput is one reduction per P+2 cycles.
- `done` and `busy` are registered. No combinational path from inputs to outputs.

## Configuration

- `CLUSTER_ACC_REDUCE_EMPTY_FLAG_EN` defined: at FINISH, `empty_mask[k]` is set to `(total cnt k == 0)`. Downstream uses this to skip division for empty clusters.
- Not defined: `empty_mask` is tied to 0 and the K zero-compare logic is not built. Port list unchanged.

## Test plan

- Reset mid-ACCUM: P=4, K=16. Assert `start`, drop `rst_n` at cycle 2 → all outputs 0, `busy`=0 immediately. After release, the next `start` gives a correct result.
- Basic, K=16, P=2: partition 0 cluster 3 R/G/B = 100/200/300, cnt 5; partition 1 = 1/2/3, cnt 7; all else 0 → `done` 3 cycles after `start`; cluster 3 = 101/202/303, cnt 12; every other cluster 0.
- Max values, AW=24, CW=12, P=4: all fields all-ones → each colour sum = 4*(2^24-1) = 67108860 (26 bits), each cnt = 16380. No wrap.
- Back-to-back and ignored `start`: second `start` pulses during ACCUM and FINISH → ignored. `start` in the cycle after `done` → accepted. Outputs hold the first result until the second `done`.
- P=1, K=4: `done` 2 cycles after `start`; outputs equal the inputs zero-extended.
- Empty flag, with `CLUSTER_ACC_REDUCE_EMPTY_FLAG_EN`: counts 0 for clusters 2 and 7 in all partitions → `empty_mask`=16'h0084. Without the macro → `empty_mask`=0.
